dvp_window_packer: RTL and testbench

Parametrised camera capture front-end for the camera → HyperRAM frame buffer → HDMI path. It takes DVP pixel samples (VSYNC/HREF/PIXDATA) that have already been retimed into the system clock with a one-cycle pixel strobe. It crops a programmable window, optionally 2:1 decimates, and packs pixel MSBs into OUT_W-bit words. Words are buffered in a small FIFO and presented on a valid/ready stream with frame and line markers, ready for the HyperRAM write controller.

---
 rtl/dvp_window_packer_if.sv | 21 ++
 rtl/dvp_window_packer.sv | 225 ++++++++++++++++++++++
 tb/tb_dvp_window_packer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_window_packer_if.sv
// rtl/dvp_window_packer_if.sv - packed-word stream with frame/line markers
interface dvp_window_packer_if #(
    parameter int OUT_W = 32
) ();
    logic [OUT_W-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             sof;
    logic             eol;
    logic             eof;

    modport master (
        output tdata, tvalid, sof, eol, eof,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, sof, eol, eof,
        output tready
    );
endinterface

// File: rtl/dvp_window_packer.sv
// rtl/dvp_window_packer.sv - DVP window crop, 2:1 decimation, MSB packing and output FIFO
module dvp_window_packer #(
    parameter int PIX_W      = 10,
    parameter int PACK_BITS  = 8,
    parameter int OUT_W      = 32,
    parameter int CNT_W      = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_pix_stb,
    input  logic             I_vsync,
    input  logic             I_href,
    input  logic [PIX_W-1:0] I_pixdata,
    input  logic             I_en,
    input  logic [CNT_W-1:0] I_x0,
    input  logic [CNT_W-1:0] I_y0,
    input  logic [CNT_W-1:0] I_w,
    input  logic [CNT_W-1:0] I_h,
    input  logic             I_dec,
    input  logic             I_clr,
    output logic             O_err,
    output logic [15:0]      O_frame_cnt,
    dvp_window_packer_if.master m_out
);
    localparam int PPW    = OUT_W / PACK_BITS;
    localparam int LANE_W = $clog2(PPW + 1);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = OUT_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DROP} state_t;
    state_t state, state_nxt;

    logic                 vsync_q, href_q;
    logic                 vsync_rise, vsync_fall, href_fall, frame_start;
    logic [CNT_W-1:0]     col, row, x0_r, y0_r, w_r, h_r;
    logic                 dec_r;
    logic [CNT_W-1:0]     dx, dy, w_m1, h_m1, last_dx, last_dy;
    logic                 in_x, in_y, dec_ok, capturing, pix_acc, flush;
    logic                 is_last_col, is_last_row, lane_full;
    logic                 frame_done, sof_pending;
    logic [PACK_BITS-1:0] pix_msb;
    logic [OUT_W-1:0]     lanes, lanes_nxt;
    logic [LANE_W-1:0]    lane_cnt;

    logic                 wr_q, wr_sof, wr_eol, wr_eof;
    logic [OUT_W-1:0]     wr_data;

    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [ENT_W-1:0]     head;
    logic [ADDR_W-1:0]    rd_ptr, wr_ptr;
    logic [ADDR_W:0]      fifo_cnt;
    logic                 fifo_full, fifo_pop, fifo_push, wr_ok, overflow, short_frame;
    logic                 unused_pix;

    assign unused_pix  = ^I_pixdata;

    assign vsync_rise  = I_vsync & ~vsync_q;
    assign vsync_fall  = ~I_vsync & vsync_q;
    assign href_fall   = href_q & ~I_href;
    assign frame_start = (state == S_IDLE || state == S_ARMED) && vsync_fall && I_en;

    // Window position of the current sample; a wrapped difference fails the < w/h test.
    assign dx      = col - x0_r;
    assign dy      = row - y0_r;
    assign w_m1    = w_r - CNT_W'(1);
    assign h_m1    = h_r - CNT_W'(1);
    assign last_dx = dec_r ? {w_m1[CNT_W-1:1], 1'b0} : w_m1;
    assign last_dy = dec_r ? {h_m1[CNT_W-1:1], 1'b0} : h_m1;
    assign in_x    = (col >= x0_r) && (dx < w_r);
    assign in_y    = (row >= y0_r) && (dy < h_r);
    assign dec_ok  = !dec_r || (!dx[0] && !dy[0]);

    assign capturing   = (state == S_ACTIVE) && !frame_done;
    assign pix_acc     = capturing && I_pix_stb && I_href && in_x && in_y && dec_ok;
    assign is_last_col = (dx == last_dx);
    assign is_last_row = (dy == last_dy);
    assign lane_full   = (lane_cnt == LANE_W'(PPW - 1));
    assign flush       = capturing && href_fall && (lane_cnt != '0);
    assign pix_msb     = I_pixdata[PIX_W-1 -: PACK_BITS];

    // Drop the new pixel's MSBs into the next free lane.
    always_comb begin
        lanes_nxt = lanes;
        for (int i = 0; i < PPW; i++) begin
            if (lane_cnt == LANE_W'(i)) begin
                lanes_nxt[i*PACK_BITS +: PACK_BITS] = pix_msb;
            end
        end
    end

    // Next-state logic for capture control.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (vsync_fall && I_en) state_nxt = S_ACTIVE;
            S_ARMED:  if (vsync_fall) state_nxt = I_en ? S_ACTIVE : S_IDLE;
            S_ACTIVE: if (vsync_rise) state_nxt = S_ARMED;
                      else if (overflow) state_nxt = S_DROP;
            S_DROP:   if (vsync_rise) state_nxt = S_ARMED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register and sync edge-detect history.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state   <= S_IDLE;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_q <= I_vsync;
            href_q  <= I_href;
        end
    end

    // Position counters, window latch and lane packing; emits one word per cycle at most.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            col         <= '0;
            row         <= '0;
            x0_r        <= '0;
            y0_r        <= '0;
            w_r         <= '0;
            h_r         <= '0;
            dec_r       <= 1'b0;
            lanes       <= '0;
            lane_cnt    <= '0;
            frame_done  <= 1'b0;
            sof_pending <= 1'b0;
            wr_q        <= 1'b0;
            wr_sof      <= 1'b0;
            wr_eol      <= 1'b0;
            wr_eof      <= 1'b0;
            wr_data     <= '0;
        end else begin
            wr_q <= 1'b0;
            if (I_pix_stb && I_href) col <= col + CNT_W'(1);
            if (href_fall) begin
                col <= '0;
                row <= row + CNT_W'(1);
            end
            if (frame_start) begin
                x0_r        <= I_x0;
                y0_r        <= I_y0;
                w_r         <= I_w;
                h_r         <= I_h;
                dec_r       <= I_dec;
                col         <= '0;
                row         <= '0;
                lanes       <= '0;
                lane_cnt    <= '0;
                frame_done  <= 1'b0;
                sof_pending <= 1'b1;
            end else if (pix_acc) begin
                if (lane_full || is_last_col) begin
                    wr_q        <= 1'b1;
                    wr_data     <= lanes_nxt;
                    wr_sof      <= sof_pending;
                    wr_eol      <= is_last_col;
                    wr_eof      <= is_last_col && is_last_row;
                    lanes       <= '0;
                    lane_cnt    <= '0;
                    sof_pending <= 1'b0;
                    if (is_last_col && is_last_row) frame_done <= 1'b1;
                end else begin
                    lanes    <= lanes_nxt;
                    lane_cnt <= lane_cnt + LANE_W'(1);
                end
            end else if (flush) begin
                wr_q        <= 1'b1;
                wr_data     <= lanes;
                wr_sof      <= sof_pending;
                wr_eol      <= 1'b1;
                wr_eof      <= is_last_row;
                lanes       <= '0;
                lane_cnt    <= '0;
                sof_pending <= 1'b0;
                if (is_last_row) frame_done <= 1'b1;
            end
        end
    end

    assign fifo_pop    = m_out.tvalid && m_out.tready;
    assign fifo_full   = (fifo_cnt == (ADDR_W+1)'(FIFO_DEPTH));
    assign wr_ok       = wr_q && (state != S_DROP);
    assign overflow    = wr_ok && fifo_full && !fifo_pop;
    assign fifo_push   = wr_ok && !overflow;
    assign short_frame = (state == S_ACTIVE) && vsync_rise && !frame_done;

    // FIFO storage; contents are only visible while the entry count is non-zero.
    always_ff @(posedge I_clk) begin
        if (fifo_push) mem[wr_ptr] <= {wr_sof, wr_eol, wr_eof, wr_data};
    end

    // FIFO pointers, occupancy, frame counter and sticky error.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            O_frame_cnt <= '0;
            O_err       <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (ADDR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (ADDR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (fifo_push && wr_eof) O_frame_cnt <= O_frame_cnt + 16'd1;
            if (overflow || short_frame) O_err <= 1'b1;
            else if (I_clr)              O_err <= 1'b0;
        end
    end

    assign head         = mem[rd_ptr];
    assign m_out.tvalid = (fifo_cnt != '0);
    assign m_out.tdata  = m_out.tvalid ? head[OUT_W-1:0] : '0;
    assign m_out.eof    = m_out.tvalid & head[OUT_W];
    assign m_out.eol    = m_out.tvalid & head[OUT_W+1];
    assign m_out.sof    = m_out.tvalid & head[OUT_W+2];
endmodule

// File: tb/tb_dvp_window_packer.sv
// tb/tb_dvp_window_packer.sv - scoreboard bench for dvp_window_packer
module tb_dvp_window_packer;
    localparam int PIX_W = 10;
    localparam int CNT_W = 12;
    localparam int OUT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pix_stb = 1'b0;
    logic             vsync = 1'b0;
    logic             href = 1'b0;
    logic [PIX_W-1:0] pixdata = '0;
    logic             en = 1'b1;
    logic [CNT_W-1:0] x0 = '0, y0 = '0, w = 12'd1, h = 12'd1;
    logic             dec = 1'b0;
    logic             clr = 1'b0;
    logic             err;
    logic [15:0]      frame_cnt;

    dvp_window_packer_if #(.OUT_W(OUT_W)) bus ();

    dvp_window_packer #(
        .PIX_W(PIX_W), .PACK_BITS(8), .OUT_W(OUT_W), .CNT_W(CNT_W), .FIFO_DEPTH(16)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_pix_stb(pix_stb), .I_vsync(vsync),
        .I_href(href), .I_pixdata(pixdata), .I_en(en), .I_x0(x0), .I_y0(y0),
        .I_w(w), .I_h(h), .I_dec(dec), .I_clr(clr), .O_err(err),
        .O_frame_cnt(frame_cnt), .m_out(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [OUT_W+2:0] exp_q[$];
    bit lat_probe = 1'b0;
    int lat_stb_cyc = -1;
    int lat_valid_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (lat_probe && bus.tvalid && lat_valid_cyc < 0) lat_valid_cyc = cyc;
        if (rst_n && bus.tvalid && bus.tready) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_word observed=%h required=none", bus.tdata);
            end
            if (exp_q.size() != 0) begin
                logic [OUT_W+2:0] e;
                e = exp_q.pop_front();
                n_tests++;
                assert ({bus.sof, bus.eol, bus.eof, bus.tdata} === e) else begin
                    n_fail++;
                    $error("FAIL word observed=%h required=%h",
                           {bus.sof, bus.eol, bus.eof, bus.tdata}, e);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit s, input bit l, input bit f, input logic [31:0] d);
        exp_q.push_back({s, l, f, d});
    endtask

    task automatic set_win(input int ax0, input int ay0, input int aw, input int ah, input bit ad);
        x0 = CNT_W'(ax0); y0 = CNT_W'(ay0); w = CNT_W'(aw); h = CNT_W'(ah); dec = ad;
    endtask

    task automatic send_pix(input int c);
        pix_stb = 1'b1; href = 1'b1; pixdata = PIX_W'(c << 2);
        tick();
        pix_stb = 1'b0;
        tick();
    endtask

    task automatic send_line(input int l, input int npix);
        for (int c = 0; c < npix; c++) begin
            if (lat_probe && l == 1 && c == 5) lat_stb_cyc = cyc;
            pix_stb = 1'b1; href = 1'b1; pixdata = PIX_W'(c << 2);
            tick();
            pix_stb = 1'b0;
            tick();
        end
        href = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int nlines, input int npix);
        vsync = 1'b1; repeat (3) tick();
        vsync = 1'b0; repeat (3) tick();
        for (int l = 0; l < nlines; l++) send_line(l, npix);
        vsync = 1'b1; repeat (3) tick();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        check(tag, exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        clr = 1'b1; tick(); clr = 1'b0; tick();
    endtask

    task automatic expect_t1();
        push_exp(1, 0, 0, 32'h05040302);
        push_exp(0, 1, 0, 32'h09080706);
        push_exp(0, 0, 0, 32'h05040302);
        push_exp(0, 1, 1, 32'h09080706);
    endtask

    initial begin
        bus.tready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("rst_valid", bus.tvalid, 0);
        check("rst_data", bus.tdata, 0);
        check("rst_flags", {bus.sof, bus.eol, bus.eof}, 0);
        check("rst_err", err, 0);
        check("rst_fcnt", frame_cnt, 0);
        tick();

        // Basic crop, two full words per window line, plus first-word latency.
        set_win(2, 1, 8, 2, 0);
        expect_t1();
        lat_probe = 1'b1;
        send_frame(3, 12);
        lat_probe = 1'b0;
        wait_drain("t1_drain");
        check("t1_latency", lat_valid_cyc - lat_stb_cyc, 2);
        check("t1_fcnt", frame_cnt, 1);
        check("t1_err", err, 0);

        // Partial last word padded with zero lanes.
        set_win(2, 1, 6, 2, 0);
        push_exp(1, 0, 0, 32'h05040302);
        push_exp(0, 1, 0, 32'h00000706);
        push_exp(0, 0, 0, 32'h05040302);
        push_exp(0, 1, 1, 32'h00000706);
        send_frame(3, 12);
        wait_drain("t2_drain");
        check("t2_fcnt", frame_cnt, 2);

        // 2:1 decimation in both directions.
        set_win(0, 0, 8, 4, 1);
        push_exp(1, 1, 0, 32'h06040200);
        push_exp(0, 1, 1, 32'h06040200);
        send_frame(4, 12);
        wait_drain("t3_drain");
        check("t3_fcnt", frame_cnt, 3);

        // Overflow: 20 words into a stalled 16-entry FIFO.
        set_win(0, 0, 8, 10, 0);
        bus.tready = 1'b0;
        for (int i = 0; i < 16; i++)
            push_exp(i == 0, i % 2, 0, (i % 2) ? 32'h07060504 : 32'h03020100);
        send_frame(10, 12);
        @(negedge clk);
        check("t4_hold_valid", bus.tvalid, 1);
        check("t4_hold_data", bus.tdata, 32'h03020100);
        check("t4_hold_sof", bus.sof, 1);
        check("t4_err", err, 1);
        check("t4_fcnt", frame_cnt, 3);
        tick();
        bus.tready = 1'b1;
        wait_drain("t4_drain");
        pulse_clr();
        @(negedge clk);
        check("t4_err_clr", err, 0);
        tick();
        set_win(2, 1, 8, 2, 0);
        expect_t1();
        send_frame(3, 12);
        wait_drain("t4_recover_drain");
        check("t4_recover_fcnt", frame_cnt, 4);
        check("t4_recover_err", err, 0);

        // Short frame: vsync rises after only one of two window rows.
        set_win(2, 1, 8, 2, 0);
        push_exp(1, 0, 0, 32'h05040302);
        push_exp(0, 1, 0, 32'h09080706);
        send_frame(2, 12);
        wait_drain("t5_drain");
        check("t5_err", err, 1);
        check("t5_fcnt", frame_cnt, 4);
        pulse_clr();
        @(negedge clk);
        check("t5_err_clr", err, 0);
        tick();

        // Reset mid-line, then a clean frame.
        vsync = 1'b1; repeat (3) tick();
        vsync = 1'b0; repeat (3) tick();
        send_line(0, 12);
        for (int c = 0; c < 4; c++) send_pix(c);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_valid", bus.tvalid, 0);
        check("t6_data", bus.tdata, 0);
        check("t6_fcnt", frame_cnt, 0);
        check("t6_err", err, 0);
        tick();
        href = 1'b0;
        rst_n = 1'b1;
        vsync = 1'b1;
        repeat (3) tick();
        expect_t1();
        send_frame(3, 12);
        wait_drain("t6_drain");
        check("t6_fcnt_after", frame_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
